// File: rtl/icw_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : icw_sequencer_pkg
// Description : Shared state encodings, command-byte bit indices and pulse
//               slot indices for the ICW sequencer and ICW/OCW registers.
// Revision    : 1.0 - initial release
// ============================================================================
package icw_sequencer_pkg;

    typedef enum logic [2:0] {
        UNINIT    = 3'd0,
        WAIT_ICW2 = 3'd1,
        WAIT_ICW3 = 3'd2,
        WAIT_ICW4 = 3'd3,
        READY     = 3'd4
    } state_t;

    localparam int ICW1_IC4  = 0;
    localparam int ICW1_SNGL = 1;
    localparam int SEL_D3    = 3;
    localparam int SEL_D4    = 4;

    localparam int PULSE_W    = 7;
    localparam int PULSE_ICW1 = 0;
    localparam int PULSE_ICW2 = 1;
    localparam int PULSE_ICW3 = 2;
    localparam int PULSE_ICW4 = 3;
    localparam int PULSE_OCW1 = 4;
    localparam int PULSE_OCW2 = 5;
    localparam int PULSE_OCW3 = 6;

    // Operational-mode decode of a non-ICW1 write.
    function automatic logic [PULSE_W-1:0] ocw_decode(input logic a0, input logic [7:0] data);
        logic [PULSE_W-1:0] p;
        p = '0;
        if (a0) begin
            p[PULSE_OCW1] = 1'b1;
        end else if (!data[SEL_D4]) begin
            if (data[SEL_D3]) p[PULSE_OCW3] = 1'b1;
            else              p[PULSE_OCW2] = 1'b1;
        end
        return p;
    endfunction

endpackage : icw_sequencer_pkg
`default_nettype wire

// File: rtl/icw_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : icw_sequencer
// Description : Initialization-command-word sequencer: tracks ICW1..ICW4 and
//               emits registered single-cycle ICW/OCW load pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module icw_sequencer
    import icw_sequencer_pkg::*;
#(
    parameter bit OCW_BEFORE_INIT = 1'b0
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       write_strobe,
    input  logic       address_0,
    input  logic [7:0] internal_data_bus,
    output logic       write_initial_command_word_1,
    output logic       write_initial_command_word_2,
    output logic       write_initial_command_word_3,
    output logic       write_initial_command_word_4,
    output logic       write_operation_control_word_1,
    output logic       write_operation_control_word_2,
    output logic       write_operation_control_word_3,
    output logic       init_in_progress,
    output logic       init_done,
    output logic [2:0] sequence_state
);

    state_t               r_state;
    state_t               w_next_state;
    logic                 r_single_mode;
    logic                 r_icw4_required;
    logic                 w_single_next;
    logic                 w_icw4_next;
    logic [PULSE_W-1:0]   r_pulse;
    logic [PULSE_W-1:0]   w_pulse;
    logic                 w_is_icw1;
    logic                 w_legal_state;

    assign w_is_icw1     = write_strobe && !address_0 && internal_data_bus[SEL_D4];
    assign w_legal_state = (r_state <= READY);

    always_comb begin
        w_next_state  = r_state;
        w_pulse       = '0;
        w_single_next = r_single_mode;
        w_icw4_next   = r_icw4_required;
        if (!w_legal_state) begin
            w_next_state = UNINIT;
        end else if (w_is_icw1) begin
            // ICW1 always (re)starts the sequence, whatever the current state.
            w_pulse[PULSE_ICW1] = 1'b1;
            w_single_next       = internal_data_bus[ICW1_SNGL];
            w_icw4_next         = internal_data_bus[ICW1_IC4];
            w_next_state        = WAIT_ICW2;
        end else if (write_strobe) begin
            case (r_state)
                UNINIT: begin
                    if (OCW_BEFORE_INIT) w_pulse = ocw_decode(address_0, internal_data_bus);
                end
                WAIT_ICW2: begin
                    if (address_0) begin
                        w_pulse[PULSE_ICW2] = 1'b1;
                        if (!r_single_mode)       w_next_state = WAIT_ICW3;
                        else if (r_icw4_required) w_next_state = WAIT_ICW4;
                        else                      w_next_state = READY;
                    end
                end
                WAIT_ICW3: begin
                    if (address_0) begin
                        w_pulse[PULSE_ICW3] = 1'b1;
                        w_next_state        = r_icw4_required ? WAIT_ICW4 : READY;
                    end
                end
                WAIT_ICW4: begin
                    if (address_0) begin
                        w_pulse[PULSE_ICW4] = 1'b1;
                        w_next_state        = READY;
                    end
                end
                READY: begin
                    w_pulse = ocw_decode(address_0, internal_data_bus);
                end
                default: begin
                    w_next_state = UNINIT;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= UNINIT;
            r_single_mode   <= 1'b0;
            r_icw4_required <= 1'b0;
            r_pulse         <= '0;
        end else begin
            r_state         <= w_next_state;
            r_single_mode   <= w_single_next;
            r_icw4_required <= w_icw4_next;
            r_pulse         <= w_pulse;
        end
    end

    assign write_initial_command_word_1   = r_pulse[PULSE_ICW1];
    assign write_initial_command_word_2   = r_pulse[PULSE_ICW2];
    assign write_initial_command_word_3   = r_pulse[PULSE_ICW3];
    assign write_initial_command_word_4   = r_pulse[PULSE_ICW4];
    assign write_operation_control_word_1 = r_pulse[PULSE_OCW1];
    assign write_operation_control_word_2 = r_pulse[PULSE_OCW2];
    assign write_operation_control_word_3 = r_pulse[PULSE_OCW3];

    assign init_in_progress = (r_state == WAIT_ICW2) || (r_state == WAIT_ICW3) || (r_state == WAIT_ICW4);
    assign init_done        = (r_state == READY);
    assign sequence_state   = r_state;

endmodule : icw_sequencer
`default_nettype wire

// File: tb/tb_icw_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_icw_sequencer
// Description : Directed self-checking bench for icw_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_icw_sequencer;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       write_strobe = 1'b0;
    logic       address_0 = 1'b0;
    logic [7:0] internal_data_bus = 8'h00;
    logic       icw1, icw2, icw3, icw4, ocw1, ocw2, ocw3;
    logic       init_in_progress, init_done;
    logic [2:0] sequence_state;

    int n_checks = 0;
    int n_fail   = 0;

    // Pulse vector order: {ocw3, ocw2, ocw1, icw4, icw3, icw2, icw1}
    localparam logic [6:0] P_NONE = 7'b0000000;
    localparam logic [6:0] P_ICW1 = 7'b0000001;
    localparam logic [6:0] P_ICW2 = 7'b0000010;
    localparam logic [6:0] P_ICW3 = 7'b0000100;
    localparam logic [6:0] P_ICW4 = 7'b0001000;
    localparam logic [6:0] P_OCW1 = 7'b0010000;
    localparam logic [6:0] P_OCW2 = 7'b0100000;
    localparam logic [6:0] P_OCW3 = 7'b1000000;

    icw_sequencer #(.OCW_BEFORE_INIT(1'b0)) dut (
        .clock                          (clock),
        .reset_n                        (reset_n),
        .write_strobe                   (write_strobe),
        .address_0                      (address_0),
        .internal_data_bus              (internal_data_bus),
        .write_initial_command_word_1   (icw1),
        .write_initial_command_word_2   (icw2),
        .write_initial_command_word_3   (icw3),
        .write_initial_command_word_4   (icw4),
        .write_operation_control_word_1 (ocw1),
        .write_operation_control_word_2 (ocw2),
        .write_operation_control_word_3 (ocw3),
        .init_in_progress               (init_in_progress),
        .init_done                      (init_done),
        .sequence_state                 (sequence_state)
    );

    always #5 clock = ~clock;

    function automatic logic [6:0] pulses();
        return {ocw3, ocw2, ocw1, icw4, icw3, icw2, icw1};
    endfunction

    task automatic apply_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    // One write per call; successive calls land on consecutive rising edges.
    task automatic do_write(input logic a0, input logic [7:0] d);
        @(negedge clock);
        write_strobe      = 1'b1;
        address_0         = a0;
        internal_data_bus = d;
        @(posedge clock);
        #1;
        write_strobe      = 1'b0;
        address_0         = 1'b0;
        internal_data_bus = 8'h00;
    endtask

    task automatic check_step(input string name, input logic [6:0] exp_p, input logic [2:0] exp_s);
        n_checks++;
        if (pulses() !== exp_p) begin
            n_fail++;
            $display("FAIL %s_pulse: actual %b required %b", name, pulses(), exp_p);
        end
        n_checks++;
        if (sequence_state !== exp_s) begin
            n_fail++;
            $display("FAIL %s_state: actual %0d required %0d", name, sequence_state, exp_s);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #1;
        check_step("reset", P_NONE, 3'd0);
        n_checks++;
        if ({init_in_progress, init_done} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_flags: actual %b required 00", {init_in_progress, init_done});
        end
        apply_reset();
    endtask

    task automatic test_cascade();
        apply_reset();
        do_write(1'b0, 8'h11); check_step("cascade_icw1", P_ICW1, 3'd1);
        n_checks++;
        if (init_in_progress !== 1'b1) begin
            n_fail++;
            $display("FAIL cascade_in_progress: actual %b required 1", init_in_progress);
        end
        do_write(1'b1, 8'h20); check_step("cascade_icw2", P_ICW2, 3'd2);
        do_write(1'b1, 8'h04); check_step("cascade_icw3", P_ICW3, 3'd3);
        do_write(1'b1, 8'h01); check_step("cascade_icw4", P_ICW4, 3'd4);
        n_checks++;
        if ({init_in_progress, init_done} !== 2'b01) begin
            n_fail++;
            $display("FAIL cascade_done_flags: actual %b required 01", {init_in_progress, init_done});
        end
        @(posedge clock); #1;
        check_step("cascade_idle", P_NONE, 3'd4);
    endtask

    task automatic test_single_no_icw4();
        apply_reset();
        do_write(1'b0, 8'h12); check_step("single_icw1", P_ICW1, 3'd1);
        do_write(1'b1, 8'h08); check_step("single_icw2", P_ICW2, 3'd4);
        @(posedge clock); #1;
        check_step("single_idle", P_NONE, 3'd4);
    endtask

    task automatic test_restart();
        apply_reset();
        do_write(1'b0, 8'h11); check_step("restart_icw1a", P_ICW1, 3'd1);
        do_write(1'b1, 8'h20); check_step("restart_icw2a", P_ICW2, 3'd2);
        do_write(1'b0, 8'h13); check_step("restart_icw1b", P_ICW1, 3'd1);
        // A0=0/D4=0 write is ignored while waiting for ICW2
        do_write(1'b0, 8'h08); check_step("restart_ignored", P_NONE, 3'd1);
        // single_mode=1 and icw4_required=1 now: ICW2 skips straight to WAIT_ICW4
        do_write(1'b1, 8'h00); check_step("restart_icw2b", P_ICW2, 3'd3);
        do_write(1'b1, 8'h01); check_step("restart_icw4", P_ICW4, 3'd4);
    endtask

    task automatic test_ocw_ready();
        do_write(1'b1, 8'hFF); check_step("ready_ocw1", P_OCW1, 3'd4);
        do_write(1'b0, 8'h20); check_step("ready_ocw2", P_OCW2, 3'd4);
        do_write(1'b0, 8'h0B); check_step("ready_ocw3", P_OCW3, 3'd4);
        @(posedge clock); #1;
        check_step("ready_idle", P_NONE, 3'd4);
    endtask

    task automatic test_uninit_ignore();
        apply_reset();
        do_write(1'b1, 8'hFF); check_step("uninit_a0_1", P_NONE, 3'd0);
        do_write(1'b0, 8'h20); check_step("uninit_a0_0", P_NONE, 3'd0);
    endtask

    task automatic test_reset_mid_sequence();
        apply_reset();
        do_write(1'b0, 8'h10); check_step("abort_icw1", P_ICW1, 3'd1);
        do_write(1'b1, 8'h20); check_step("abort_icw2", P_ICW2, 3'd2);
        #2;
        reset_n = 1'b0;
        #1;
        check_step("abort_async", P_NONE, 3'd0);
        n_checks++;
        if ({init_in_progress, init_done} !== 2'b00) begin
            n_fail++;
            $display("FAIL abort_flags: actual %b required 00", {init_in_progress, init_done});
        end
        @(negedge clock);
        reset_n = 1'b1;
        do_write(1'b1, 8'h04); check_step("abort_after", P_NONE, 3'd0);
    endtask

    initial begin
        test_reset();
        test_cascade();
        test_single_no_icw4();
        test_restart();
        test_ocw_ready();
        test_uninit_ignore();
        test_reset_mid_sequence();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_icw_sequencer
`default_nettype wire

// File: doc/icw_sequencer.md
ICW_SEQUENCER -- requirements
Module: icw_sequencer

Interface
REQ-001 The block SHALL have parameter OCW_BEFORE_INIT, default 0, meaning that 1 enables OCW decode before the first completed initialization.
REQ-002 The block SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-004 The block SHALL have port write_strobe, input, 1 bit: one-cycle write request from the bus interface, already synchronous to clock.
REQ-005 The block SHALL have port address_0, input, 1 bit: the A0 value qualifying the write.
REQ-006 The block SHALL have port internal_data_bus, input, 8 bits: the write data.
REQ-007 The block SHALL have outputs write_initial_command_word_1 … _4, 1 bit each: single-cycle ICW load pulses to the ICW registers.
REQ-008 The block SHALL have outputs write_operation_control_word_1 … _3, 1 bit each: single-cycle OCW load pulses.
REQ-009 The block SHALL have output init_in_progress, 1 bit: high from an accepted ICW1 until the sequence completes.
REQ-010 The block SHALL have output init_done, 1 bit: high in READY.
REQ-011 The block SHALL have output sequence_state, 3 bits: the current FSM state encoding.

Function
REQ-012 The FSM SHALL have the states UNINIT=0, WAIT_ICW2=1, WAIT_ICW3=2, WAIT_ICW4=3 and READY=4; encodings 5-7 are illegal and SHALL go to UNINIT on the next clock.
REQ-013 Writes SHALL be sampled only on edges where write_strobe=1.
REQ-014 An ICW1 write SHALL be A0=0 with D4=1; it is accepted in every state.
- It pulses ICW1, latches single_mode=D1 and icw4_required=D0, and enters WAIT_ICW2.
- A mid-sequence ICW1 restarts the sequence.
REQ-015 In WAIT_ICW2, an A0=1 write SHALL pulse ICW2 and then go to:
- WAIT_ICW3 if single_mode=0;
- else WAIT_ICW4 if icw4_required=1;
- else READY.
REQ-016 In WAIT_ICW3, an A0=1 write SHALL pulse ICW3 and go to WAIT_ICW4 if icw4_required=1, else READY.
REQ-017 In WAIT_ICW4, an A0=1 write SHALL pulse ICW4 and go to READY.
REQ-018 In WAIT_ICW2/3/4, an A0=0 write with D4=0 SHALL be ignored: no pulse, no state change.
REQ-019 In READY, writes SHALL decode as follows, with the state unchanged:
- A0=1 → OCW1;
- A0=0, D4=0, D3=0 → OCW2;
- A0=0, D4=0, D3=1 → OCW3.
REQ-020 In UNINIT, non-ICW1 writes SHALL be ignored when OCW_BEFORE_INIT=0, and decoded as in READY when it is 1.
REQ-021 All pulse outputs SHALL be registered: high exactly the one cycle following the sampling edge, 1-cycle latency.
REQ-022 At most one pulse output SHALL be high in any cycle.
REQ-023 Back-to-back writes on consecutive cycles SHALL each be processed, with no lost write.
REQ-024 init_in_progress SHALL equal (state ∈ {WAIT_ICW2, WAIT_ICW3, WAIT_ICW4}) and init_done SHALL equal (state==READY), both driven combinationally from the state register.

Reset
REQ-025 Asserting reset_n=0 SHALL immediately force:
- state=UNINIT;
- single_mode=0 and icw4_required=0;
- all pulse outputs 0, init_in_progress=0, init_done=0, sequence_state=0.
REQ-026 Reset mid-sequence SHALL abort the sequence; a fresh ICW1 is required afterwards.
REQ-027 The first write SHALL be sampled on the first rising edge after reset_n deasserts.

Structure
REQ-028 The state encodings and the bit-index constants (ICW1_IC4=0, ICW1_SNGL=1, SEL_D3=3, SEL_D4=4) SHALL live in shared package icw_sequencer_pkg, reused by the ICW and OCW register blocks.
REQ-029 The block SHALL be a single module with no sub-module, consisting of:
- the FSM;
- the config latch;
- the pulse register.

Verification
REQ-030 Cascade with ICW4: writes (A0,D) = (0,0x11), (1,0x20), (1,0x04), (1,0x01) → pulses ICW1, ICW2, ICW3, ICW4 on successive cycles, with init_done=1 after the fourth pulse.
REQ-031 Single without ICW4: writes (0,0x12), (1,0x08) → pulses ICW1 then ICW2, READY, and no ICW3/ICW4 pulse.
REQ-032 Restart: writes (0,0x11), (1,0x20), then (0,0x13) → the third write pulses ICW1 again, state=WAIT_ICW2, and single_mode=1.
REQ-033 OCW decode in READY: writes (1,0xFF), (0,0x20), (0,0x0B) → pulses OCW1, OCW2, OCW3, with the state remaining READY.
REQ-034 UNINIT with OCW_BEFORE_INIT=0: writes (1,0xFF) and (0,0x20) → no pulses and the state remains 0.
REQ-035 Reset mid-sequence: reset_n asserted asynchronously in WAIT_ICW3 → state=0 and outputs cleared in the same cycle, and a subsequent (1,0x04) write is ignored.
